// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with a start/busy/done handshake and a registered result.
// Single-pass ops: AND, OR, ADD, SUB, SLT. Iterative ops: MUL (shift-add), SLL and SRL.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start, op, a, b  request and operands, sampled only while busy=0
//   busy             an operation is in progress
//   done             one-cycle pulse when out/zero/over update
//   out, zero, over  registered result, zero flag and overflow flag
module seq_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             over
);

  // One extra bit so the counter can hold WIDTH and any shift amount.
  localparam int unsigned CW = SHW + 1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 shnz_q, shnz_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     out_q, out_d;
  logic                 zero_q, zero_d;
  logic                 over_q, over_d;

  logic                 sub_c;
  logic [WIDTH-1:0]     bx_c;
  logic [WIDTH-1:0]     sum_c;
  logic                 ovf_c;
  logic [WIDTH-1:0]     addend_c;
  logic [WIDTH:0]       mul_add_c;
  logic [2*WIDTH-1:0]   acc_step_c;
  logic [WIDTH-1:0]     shift_c;
  logic [WIDTH-1:0]     result_c;
  logic                 over_c;
  logic [SHW-1:0]       shamt_in;

  assign shamt_in = b[SHW-1:0];

  // Shared adder: SUB and SLT add the inverted b plus one.
  always_comb begin
    sub_c = (op_q == OP_SUB) || (op_q == OP_SLT);
    bx_c  = sub_c ? ~b_q : b_q;
    sum_c = a_q + bx_c + WIDTH'(sub_c);
    ovf_c = (a_q[WIDTH-1] == bx_c[WIDTH-1]) && (sum_c[WIDTH-1] != a_q[WIDTH-1]);
  end

  // One shift-add multiply step: multiplier sits in the low half of acc.
  always_comb begin
    addend_c   = acc_q[0] ? a_q : '0;
    mul_add_c  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend_c};
    acc_step_c = {mul_add_c, acc_q[WIDTH-1:1]};
  end

  // One-bit shift step; a zero shift amount passes a through unchanged.
  always_comb begin
    shift_c = a_q;
    if (shnz_q) begin
      shift_c = (op_q == OP_SLL) ? (a_q << 1) : (a_q >> 1);
    end
  end

  // Final result and overflow, valid on the last RUN step.
  always_comb begin
    result_c = '0;
    over_c   = 1'b0;
    case (op_q)
      OP_AND:         result_c = a_q & b_q;
      OP_OR:          result_c = a_q | b_q;
      OP_ADD, OP_SUB: begin
        result_c = sum_c;
        over_c   = ovf_c;
      end
      OP_SLT:         result_c = WIDTH'(sum_c[WIDTH-1] ^ ovf_c);
      OP_MUL: begin
        result_c = acc_step_c[WIDTH-1:0];
        over_c   = |acc_step_c[2*WIDTH-1:WIDTH];
      end
      OP_SLL, OP_SRL: result_c = shift_c;
      default:        result_c = '0;
    endcase
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    shnz_d  = shnz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    out_d   = out_q;
    zero_d  = zero_q;
    over_d  = over_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          acc_d   = {{WIDTH{1'b0}}, b};
          shnz_d  = |shamt_in;
          state_d = RUN;
          busy_d  = 1'b1;
          case (op)
            OP_MUL:         cnt_d = CW'(WIDTH);
            OP_SLL, OP_SRL: cnt_d = (|shamt_in) ? CW'(shamt_in) : CW'(1);
            default:        cnt_d = CW'(1);
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (op_q == OP_MUL) begin
          acc_d = acc_step_c;
        end
        if ((op_q == OP_SLL) || (op_q == OP_SRL)) begin
          a_d = shift_c;
        end
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          out_d   = result_c;
          zero_d  = (result_c == '0);
          over_d  = over_c;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      shnz_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
      zero_q  <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      shnz_q  <= shnz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
      over_q  <= over_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign out  = out_q;
  assign zero = zero_q;
  assign over = over_q;

endmodule
